// File: rtl/slice_add_sequencer_pkg.sv
// Shared definitions for the slice-serial adder: FSM state encoding and default widths.
package slice_add_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultN = 32;
  localparam int unsigned DefaultW = 4;

endpackage

// File: rtl/ripple_carry_adder_4_bit.sv
// Four-bit ripple-carry adder used as the shared slice adder of the sequencer.
module ripple_carry_adder_4_bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < 4; i++) begin
      sum_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[4];
  end

endmodule

// File: rtl/slice_add_sequencer.sv
// Slice-serial N-bit adder: one W-bit slice per clock through a single shared 4-bit adder.
// Optional subtract support is enabled with the SLICE_SUB_EN macro.
module slice_add_sequencer
  import slice_add_sequencer_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
`ifdef SLICE_SUB_EN
  input  logic         op_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         of,
  output logic         busy
);

  localparam int unsigned Slices = N / W;
  localparam int unsigned IdxW   = (Slices > 1) ? $clog2(Slices) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Slices - 1);

  if ((N % W) != 0) begin : gen_bad_n
    $error("slice_add_sequencer: N must be a multiple of W");
  end
  if (W != 4) begin : gen_bad_w
    $error("slice_add_sequencer: W must be 4 to match the shared slice adder");
  end

  state_e          state_q, state_d;
  logic [N-1:0]    op1_q, op1_d, op2_q, op2_d, sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d, cout_q, cout_d, of_q, of_d;
  logic            sub_q;

`ifdef SLICE_SUB_EN
  logic sub_d;
`else
  assign sub_q = 1'b0;
`endif

  int unsigned base;
  logic [W-1:0] slice_a, slice_b, slice_sum;
  logic         slice_cout;

  // Operand-slice multiplexing; the effective in2 is inverted for subtract.
  always_comb begin
    base    = W * 32'(idx_q);
    slice_a = op1_q[base +: W];
    slice_b = op2_q[base +: W] ^ {W{sub_q}};
  end

  ripple_carry_adder_4_bit u_slice_adder (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    of_d    = of_q;
`ifdef SLICE_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op1_d   = in1;
          op2_d   = in2;
          idx_d   = '0;
`ifdef SLICE_SUB_EN
          sub_d   = op_sub;
          carry_d = op_sub;
`else
          carry_d = 1'b0;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[base +: W] = slice_sum;
        carry_d          = slice_cout;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          of_d    = (slice_a[W-1] == slice_b[W-1]) && (slice_sum[W-1] != slice_a[W-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op1_q   <= '0;
      op2_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      of_q    <= 1'b0;
`ifdef SLICE_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      of_q    <= of_d;
`ifdef SLICE_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign of        = of_q;

endmodule

// File: tb/tb_slice_add_sequencer.sv
// Directed self-checking bench for slice_add_sequencer (define SLICE_SUB_EN to cover subtract).
module tb_slice_add_sequencer;

  localparam int N = 32;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, op_sub, out_valid, out_ready, cout, of, busy;
  logic [N-1:0] in1, in2, sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  slice_add_sequencer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
`ifdef SLICE_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .of        (of),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    @(negedge clk);
    in1      = a;
    in2      = b;
    op_sub   = sub;
    in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid is first seen.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sub, input logic [N-1:0] es, input logic ec, input logic eo);
    int lat;
    start_op(a, b, sub);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_of"}, 32'(of), 32'(eo));
    release_op(tag);
  endtask

  logic [N-1:0] b2b_a   [3] = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h1111_1111};
  logic [N-1:0] b2b_b   [3] = '{32'h0000_0020, 32'h0000_0002, 32'h2222_2222};
  logic [N-1:0] b2b_sum [3] = '{32'h0000_0030, 32'h0000_0001, 32'h3333_3333};

  initial begin
    int lat;
    int n;
    int prev;
    int seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
    in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_of", 32'(of), 32'd0);
    rst = 1'b0;

    // Abort during slice 3: three slices written, then asynchronous reset.
    start_op(32'h1111_1111, 32'h2222_2222, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_partial_sum", sum, 32'h0000_0333);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", sum, 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    check("abort_in_ready_after", 32'(in_ready), 32'd1);

    run_op("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("add_ripple", 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
    run_op("add_mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
    run_op("add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    check("idle_sum_retained", sum, 32'h0000_0000);

`ifdef SLICE_SUB_EN
    run_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    op_sub = 1'b0;
`endif

    // Hold in DONE with out_ready low; an in_valid pulse must be ignored.
    start_op(32'h0000_0003, 32'h0000_0004, 1'b0);
    wait_done(lat);
    check("hold_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", sum, 32'h0000_0007);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      if (i == 1) begin
        in1 = 32'h0000_0100; in2 = 32'h0000_0200; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    release_op("hold");
    repeat (3) @(negedge clk);
    check("hold_no_queued_op", 32'(busy), 32'd0);
    check("hold_sum_idle", sum, 32'h0000_0007);

    // Back-to-back with out_ready tied high.
    @(negedge clk);
    out_ready = 1'b1;
    in1 = b2b_a[0]; in2 = b2b_b[0]; in_valid = 1'b1;
    prev = 0;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("b2b_timeout", 32'(n < 40), 32'd1);
      check("b2b_sum", sum, b2b_sum[r]);
      if (r > 0) check("b2b_period", 32'(cyc - prev), 32'd10);
      prev = cyc;
      if (r < 2) begin
        in1 = b2b_a[r + 1]; in2 = b2b_b[r + 1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b_no_dup", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_add_sequencer.md
SLICE_ADD_SEQUENCER -- requirements
Module: slice_add_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits.
REQ-002 SHALL have parameter W, default 4, slice width; N SHALL be an integer multiple of W, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  sequencer able to accept operands.
REQ-007 SHALL have ports in1, in2  input  N  operands.
REQ-008 SHALL have port op_sub  input  1  1 = subtract (in1 - in2); present only when SLICE_SUB_EN is defined.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port sum  output  N  result.
REQ-012 SHALL have port cout  output  1  carry out of bit N-1.
REQ-013 SHALL have port of  output  1  two's-complement overflow flag.
REQ-014 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-015 SHALL implement a three-state machine: IDLE, RUN, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; in_valid outside IDLE SHALL be ignored, with no queuing.
REQ-017 On an edge with in_valid & in_ready, SHALL register in1/in2 (and op_sub), clear the carry register (set it to 1 for subtract), set slice index to 0 and enter RUN.
REQ-018 Each RUN edge SHALL add slice k (bits k*W+W-1 : k*W) with the carry register, write the result bits into the sum register, store the slice carry-out and increment k.
REQ-019 On the edge processing slice N/W-1, SHALL load cout and of and enter DONE; out_valid SHALL first be high exactly N/W edges after the accepting edge (8 for defaults).
REQ-020 of SHALL be 1 iff the effective operand MSBs are equal and the sum MSB differs from them (the effective in2 is inverted for subtract).
REQ-021 In DONE, SHALL hold out_valid = 1 and keep sum/cout/of stable until an edge with out_ready = 1, then enter IDLE.
REQ-022 out_valid SHALL be 0 in IDLE and RUN; sum/cout/of SHALL retain their last values in IDLE.
REQ-023 sum SHALL be (in1 + in2) mod 2^N, or (in1 - in2) mod 2^N when subtracting; for subtract, cout = 1 means no borrow.
REQ-024 The slice index SHALL be ceil(log2(N/W)) bits and SHALL never wrap within an operation.

Reset
REQ-025 While rst = 1, SHALL force state IDLE, in_ready 1, out_valid 0, busy 0, sum 0, cout 0, of 0, carry 0 and index 0, asynchronously.
REQ-026 rst asserted mid-RUN or in DONE SHALL abort the operation with no result delivered.

Configuration
REQ-027 With SLICE_SUB_EN defined, SHALL provide op_sub and the subtract behaviour of REQ-017/020/023.
REQ-028 Without SLICE_SUB_EN, SHALL omit op_sub and perform addition only, with the carry-in always 0.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default N/W constants.
REQ-030 SHALL instantiate exactly one ripple_carry_adder_4_bit (W=4) as the shared slice adder, with operand-slice multiplexing in this module.

Verification
REQ-031 0x00000001 + 0xFFFFFFFF SHALL give sum 0x00000000, cout 1, of 0, with out_valid exactly 8 edges after acceptance.
REQ-032 0x7FFFFFFF + 0x00000001 SHALL give sum 0x80000000, cout 0, of 1; 0x0FFFFFFF + 0x00000001 SHALL give 0x10000000.
REQ-033 With out_ready held 0 for 5 cycles in DONE, out_valid/sum SHALL be held and in_ready SHALL be 0; an in_valid pulse then SHALL be ignored, and out_ready=1 SHALL return the block to IDLE on the next edge.
REQ-034 rst pulsed during slice 3 SHALL immediately force out_valid 0 and sum 0; after release, in_ready SHALL be 1 and a new operation SHALL complete normally.
REQ-035 With SLICE_SUB_EN defined, 5 - 7 SHALL give 0xFFFFFFFE, cout 0, of 0, and 0x80000000 - 1 SHALL give 0x7FFFFFFF, cout 1, of 1.
REQ-036 Back-to-back accepts with out_ready tied 1 SHALL give a throughput of one result per 10 edges with no lost or duplicated results.
